seg_scan_decoder: RTL and testbench

//  Receive side of the multiplexed 7-segment scan interface (an/ca) driven by the display block.

---
 rtl/seg_scan_if.sv | 22 ++
 rtl/seg_scan_decoder.sv | 188 ++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Scan-pin and result bundle between a 7-segment scan source and its decoder.
// an/ca keep the board's ascending bit order: an[0] is the MS digit and ca[0] is segment a.
interface seg_scan_if;
    logic [0:3]  an;
    logic [0:6]  ca;
    logic        err_clr;
    logic [15:0] digits;
    logic        frame_stb;
    logic        frame_valid;
    logic        seg_err;
    logic        an_err;

    modport master (
        output an, ca, err_clr,
        input  digits, frame_stb, frame_valid, seg_err, an_err
    );

    modport slave (
        input  an, ca, err_clr,
        output digits, frame_stb, frame_valid, seg_err, an_err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed 7-segment scan: waits for each digit to settle,
// decodes the cathode pattern to a nibble and assembles four nibbles into a word.
module seg_scan_decoder #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 65536
) (
    input  logic       clk,
    input  logic       clr,
    seg_scan_if.slave  bus
);

    localparam int unsigned SW = (SETTLE  > 1) ? $clog2(SETTLE + 1) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT)    : 1;

    logic [0:3]       an_q, an_p;
    logic [0:6]       ca_q, ca_p;
    logic [SW-1:0]    settle_cnt;
    logic             captured;
    logic [TW-1:0]    idle_cnt;
    logic [3:0][3:0]  slot;
    logic [3:0]       seen;
    logic [15:0]      digits;
    logic             frame_stb;
    logic             frame_valid;
    logic             seg_err;
    logic             an_err;

    logic             chg_c;
    logic             sample_c;
    logic             onehot_c;
    logic             multi_c;
    logic [1:0]       idx_c;
    logic             dec_hit_c;
    logic [3:0]       nib_c;
    logic             hit_c;
    logic             seg_miss_c;
    logic             an_miss_c;
    logic             frame_done_c;
    logic             timeout_c;
    logic [3:0]       seen_nxt_c;

    assign bus.digits      = digits;
    assign bus.frame_stb   = frame_stb;
    assign bus.frame_valid = frame_valid;
    assign bus.seg_err     = seg_err;
    assign bus.an_err      = an_err;

    // Pin capture plus a delayed copy for change detection; idle level is blank.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            an_q <= '1;
            ca_q <= '1;
            an_p <= '1;
            ca_p <= '1;
        end else begin
            an_q <= bus.an;
            ca_q <= bus.ca;
            an_p <= an_q;
            ca_p <= ca_q;
        end
    end

    assign chg_c    = ({an_q, ca_q} != {an_p, ca_p});
    assign sample_c = !chg_c && (settle_cnt == SW'(SETTLE - 1)) && !captured;

    // Anode classification: one low anode selects a digit, all high is blank.
    always_comb begin
        onehot_c = 1'b0;
        multi_c  = 1'b0;
        idx_c    = 2'd0;
        case (an_q)
            4'b0111: begin onehot_c = 1'b1; idx_c = 2'd3; end
            4'b1011: begin onehot_c = 1'b1; idx_c = 2'd2; end
            4'b1101: begin onehot_c = 1'b1; idx_c = 2'd1; end
            4'b1110: begin onehot_c = 1'b1; idx_c = 2'd0; end
            4'b1111: ;
            default: multi_c = 1'b1;
        endcase
    end

    always_comb begin
        dec_hit_c = 1'b1;
        nib_c     = 4'h0;
        case (ca_q)
            7'b0000001: nib_c = 4'h0;
            7'b1001111: nib_c = 4'h1;
            7'b0010010: nib_c = 4'h2;
            7'b0000110: nib_c = 4'h3;
            7'b1001100: nib_c = 4'h4;
            7'b0100100: nib_c = 4'h5;
            7'b0100000: nib_c = 4'h6;
            7'b0001111: nib_c = 4'h7;
            7'b0000000: nib_c = 4'h8;
            7'b0000100: nib_c = 4'h9;
            7'b0001000: nib_c = 4'hA;
            7'b1100000: nib_c = 4'hB;
            7'b0110001: nib_c = 4'hC;
            7'b1000010: nib_c = 4'hD;
            7'b0110000: nib_c = 4'hE;
            7'b0111000: nib_c = 4'hF;
            default:    dec_hit_c = 1'b0;
        endcase
    end

    assign hit_c        = sample_c && onehot_c && dec_hit_c;
    assign seg_miss_c   = sample_c && onehot_c && !dec_hit_c;
    assign an_miss_c    = sample_c && multi_c;
    assign frame_done_c = (seen == 4'b1111);
    assign timeout_c    = !hit_c && (idle_cnt == TW'(TIMEOUT - 1));

    // A completed or timed-out frame restarts seen; a same-cycle capture lands in the new frame.
    always_comb begin
        seen_nxt_c = (frame_done_c || timeout_c) ? 4'b0000 : seen;
        if (hit_c) begin
            seen_nxt_c[idx_c] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            settle_cnt <= '0;
            captured   <= 1'b0;
        end else if (chg_c) begin
            settle_cnt <= '0;
            captured   <= 1'b0;
        end else begin
            if (settle_cnt != SW'(SETTLE)) begin
                settle_cnt <= settle_cnt + SW'(1);
            end
            if (sample_c) begin
                captured <= 1'b1;
            end
        end
    end

    // Idle counter saturates at TIMEOUT-1 until the next good capture.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            idle_cnt <= '0;
        end else if (hit_c) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TW'(TIMEOUT - 1)) begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            slot        <= '0;
            seen        <= '0;
            digits      <= '0;
            frame_stb   <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            seen      <= seen_nxt_c;
            frame_stb <= frame_done_c;
            if (hit_c) begin
                slot[idx_c] <= nib_c;
            end
            if (frame_done_c) begin
                digits      <= slot;
                frame_valid <= 1'b1;
            end else if (timeout_c) begin
                frame_valid <= 1'b0;
            end
        end
    end

    // Sticky error flags; a fresh error outranks a same-cycle clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            seg_err <= 1'b0;
            an_err  <= 1'b0;
        end else begin
            if (seg_miss_c) begin
                seg_err <= 1'b1;
            end else if (bus.err_clr) begin
                seg_err <= 1'b0;
            end
            if (an_miss_c) begin
                an_err <= 1'b1;
            end else if (bus.err_clr) begin
                an_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: table-driven frames plus hand-written
// sequences for settle, error, timeout and reset corners; frames scored via a queue.
module tb_seg_scan_decoder;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 16;

    typedef struct {
        logic [0:6] ca;
        logic [3:0] nib;
    } vec_t;

    logic clk;
    logic clr;
    int   checks;
    int   errors;
    int   cyc;
    int   stb_cnt;
    int   stb_cyc;
    int   fall_cyc;
    logic prev_fv;
    logic [15:0] exp_q[$];
    vec_t tbl[16];

    seg_scan_if bus ();

    seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame scoreboard: every frame_stb must match the oldest expected word.
    always @(negedge clk) begin
        if (clr === 1'b1 && bus.frame_stb === 1'b1) begin
            stb_cnt = stb_cnt + 1;
            stb_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_frame_stb: got digits %h with no frame expected (cycle %0d)",
                         bus.digits, cyc);
            end else begin
                chk("frame_digits", 32'(bus.digits), 32'(exp_q.pop_front()));
                chk("frame_valid_at_stb", 32'(bus.frame_valid), 32'd1);
            end
        end
        if (prev_fv === 1'b1 && bus.frame_valid === 1'b0) fall_cyc = cyc;
        prev_fv = bus.frame_valid;
    end

    function automatic logic [0:3] an_of(input int d);
        logic [0:3] a;
        case (d)
            3:       a = 4'b0111;
            2:       a = 4'b1011;
            1:       a = 4'b1101;
            default: a = 4'b1110;
        endcase
        return a;
    endfunction

    task automatic show(input logic [0:3] a, input logic [0:6] c, input int n);
        bus.an = a;
        bus.ca = c;
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        show(4'b1111, 7'b1111111, n);
    endtask

    // Scans d3..d0 using table indices, one dwell per digit.
    task automatic scan(input int i3, input int i2, input int i1, input int i0, input int dw);
        show(an_of(3), tbl[i3].ca, dw);
        show(an_of(2), tbl[i2].ca, dw);
        show(an_of(1), tbl[i1].ca, dw);
        show(an_of(0), tbl[i0].ca, dw);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_digits"},      32'(bus.digits),      32'd0);
        chk({tag, "_frame_stb"},   32'(bus.frame_stb),   32'd0);
        chk({tag, "_frame_valid"}, 32'(bus.frame_valid), 32'd0);
        chk({tag, "_seg_err"},     32'(bus.seg_err),     32'd0);
        chk({tag, "_an_err"},      32'(bus.an_err),      32'd0);
    endtask

    initial begin
        int base;
        logic [15:0] w;

        tbl[0]  = '{7'b0000001, 4'h0};
        tbl[1]  = '{7'b1001111, 4'h1};
        tbl[2]  = '{7'b0010010, 4'h2};
        tbl[3]  = '{7'b0000110, 4'h3};
        tbl[4]  = '{7'b1001100, 4'h4};
        tbl[5]  = '{7'b0100100, 4'h5};
        tbl[6]  = '{7'b0100000, 4'h6};
        tbl[7]  = '{7'b0001111, 4'h7};
        tbl[8]  = '{7'b0000000, 4'h8};
        tbl[9]  = '{7'b0000100, 4'h9};
        tbl[10] = '{7'b0001000, 4'hA};
        tbl[11] = '{7'b1100000, 4'hB};
        tbl[12] = '{7'b0110001, 4'hC};
        tbl[13] = '{7'b1000010, 4'hD};
        tbl[14] = '{7'b0110000, 4'hE};
        tbl[15] = '{7'b0111000, 4'hF};

        checks = 0; errors = 0; cyc = 0; stb_cnt = 0; stb_cyc = 0; fall_cyc = 0; prev_fv = 1'b0;
        clr = 1'b0;
        bus.err_clr = 1'b0;
        bus.an = 4'b1111;
        bus.ca = 7'b1111111;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        clr = 1'b1;
        blank(3);

        // Decode table: four frames cover all sixteen patterns.
        for (int f = 0; f < 4; f++) begin
            exp_q.push_back({tbl[4*f].nib, tbl[4*f+1].nib, tbl[4*f+2].nib, tbl[4*f+3].nib});
            scan(4*f, 4*f+1, 4*f+2, 4*f+3, 7);
        end
        blank(4);
        chk("table_frame_count", 32'(stb_cnt), 32'd4);

        // 4,1,2,F with 10-cycle dwells.
        base = stb_cnt;
        exp_q.push_back(16'h412F);
        scan(4, 1, 2, 15, 10);
        blank(4);
        chk("t1_frame_count", 32'(stb_cnt - base), 32'd1);
        chk("t1_frame_valid", 32'(bus.frame_valid), 32'd1);
        chk("t1_digits",      32'(bus.digits), 32'h412F);
        chk("t1_seg_err",     32'(bus.seg_err), 32'd0);
        chk("t1_an_err",      32'(bus.an_err), 32'd0);

        // Dwells of SETTLE-1 never capture.
        base = stb_cnt;
        for (int d = 3; d >= 0; d--) show(an_of(d), tbl[8].ca, SETTLE - 1);
        blank(4);
        chk("t2_no_short_capture", 32'(stb_cnt - base), 32'd0);
        exp_q.push_back(16'h5907);
        scan(5, 9, 0, 7, 10);
        blank(4);
        chk("t2_frame_count", 32'(stb_cnt - base), 32'd1);

        // Unknown segment pattern on one digit: error, slot/seen untouched.
        base = stb_cnt;
        exp_q.push_back(16'hCED1);
        show(an_of(3), tbl[12].ca, 6);
        show(an_of(2), tbl[14].ca, 6);
        show(an_of(0), tbl[1].ca, 6);
        show(an_of(1), 7'b1111111, 6);
        chk("t3_seg_err_set", 32'(bus.seg_err), 32'd1);
        chk("t3_an_err_clear", 32'(bus.an_err), 32'd0);
        chk("t3_no_frame_yet", 32'(stb_cnt - base), 32'd0);
        bus.err_clr = 1'b1;
        blank(1);
        bus.err_clr = 1'b0;
        chk("t3_seg_err_cleared", 32'(bus.seg_err), 32'd0);
        show(an_of(1), tbl[13].ca, 6);
        blank(4);
        chk("t3_frame_count", 32'(stb_cnt - base), 32'd1);

        // Two anodes low, then blank.
        base = stb_cnt;
        show(4'b0011, tbl[0].ca, 10);
        chk("t4_an_err_set", 32'(bus.an_err), 32'd1);
        chk("t4_seg_err_clear", 32'(bus.seg_err), 32'd0);
        bus.err_clr = 1'b1;
        blank(1);
        bus.err_clr = 1'b0;
        chk("t4_an_err_cleared", 32'(bus.an_err), 32'd0);
        blank(10);
        chk("t4_blank_an_err", 32'(bus.an_err), 32'd0);
        chk("t4_blank_seg_err", 32'(bus.seg_err), 32'd0);
        chk("t4_blank_no_frame", 32'(stb_cnt - base), 32'd0);

        // Timeout: frame_valid falls TIMEOUT-1 cycles after the strobe.
        w = 16'h9A3B;
        exp_q.push_back(w);
        scan(9, 10, 3, 11, 8);
        blank(30);
        chk("t5_valid_dropped", 32'(bus.frame_valid), 32'd0);
        chk("t5_fall_delay", 32'(fall_cyc - stb_cyc), 32'(TIMEOUT - 1));
        chk("t5_digits_held", 32'(bus.digits), 32'(w));

        // Reset mid-frame discards captured digits.
        base = stb_cnt;
        show(an_of(3), tbl[2].ca, 8);
        show(an_of(2), tbl[6].ca, 8);
        bus.an = 4'b1111;
        bus.ca = 7'b1111111;
        clr = 1'b0;
        @(negedge clk);
        chk_idle_outputs("t6_in_reset");
        repeat (2) @(negedge clk);
        clr = 1'b1;
        blank(2);
        exp_q.push_back(16'h4E8C);
        show(an_of(1), tbl[8].ca, 8);
        show(an_of(0), tbl[12].ca, 8);
        blank(3);
        chk("t6_no_frame_half", 32'(stb_cnt - base), 32'd0);
        show(an_of(3), tbl[4].ca, 8);
        show(an_of(2), tbl[14].ca, 8);
        blank(3);
        chk("t6_frame_count", 32'(stb_cnt - base), 32'd1);
        chk("t6_digits", 32'(bus.digits), 32'h4E8C);

        chk("all_frames_seen", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
